// File: rtl/memory_cycle_dual_pe.sv
// Dual-lane memory stage: EX/MEM registers, one shared single-port data memory
// arbitrated between the lanes (lane 1 first on conflict), and MEM/WB registers.
module memory_cycle_dual_pe #(
  parameter int DMEM_WORDS = 1024,
  parameter int IDX_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM1,
  input  logic        RegWriteM2,
  input  logic        MemWriteM1,
  input  logic        MemWriteM2,
  input  logic        ResultSrcM1,
  input  logic        ResultSrcM2,
  input  logic [4:0]  RD_M1,
  input  logic [4:0]  RD_M2,
  input  logic [31:0] PCPlus4M1,
  input  logic [31:0] PCPlus4M2,
  input  logic [31:0] WriteDataM1,
  input  logic [31:0] WriteDataM2,
  input  logic [31:0] ALU_ResultM1,
  input  logic [31:0] ALU_ResultM2,
  output logic        StallM,
  output logic        RegWriteW1,
  output logic        RegWriteW2,
  output logic        ResultSrcW1,
  output logic        ResultSrcW2,
  output logic [4:0]  RD_W1,
  output logic [4:0]  RD_W2,
  output logic [31:0] PCPlus4W1,
  output logic [31:0] PCPlus4W2,
  output logic [31:0] ALU_ResultW1,
  output logic [31:0] ALU_ResultW2,
  output logic [31:0] ReadDataW1,
  output logic [31:0] ReadDataW2
);

  typedef enum logic {IDLE, SERVE2} state_t;

  state_t state, state_next;

  logic        reg_write1, reg_write2;
  logic        mem_write1, mem_write2;
  logic        result_src1, result_src2;
  logic [4:0]  rd1, rd2;
  logic [31:0] pc_plus4_1, pc_plus4_2;
  logic [31:0] write_data1, write_data2;
  logic [31:0] alu_result1, alu_result2;

  logic             need1, need2, conflict, sel2;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata, mem_rdata, hold1, lane1_rdata;
  logic             mem_we;
  logic [31:0]      mem [DMEM_WORDS];

  // EX/MEM pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write1  <= 1'b0;
      reg_write2  <= 1'b0;
      mem_write1  <= 1'b0;
      mem_write2  <= 1'b0;
      result_src1 <= 1'b0;
      result_src2 <= 1'b0;
      rd1         <= '0;
      rd2         <= '0;
      pc_plus4_1  <= '0;
      pc_plus4_2  <= '0;
      write_data1 <= '0;
      write_data2 <= '0;
      alu_result1 <= '0;
      alu_result2 <= '0;
    end else if (!StallM) begin
      reg_write1  <= RegWriteM1;
      reg_write2  <= RegWriteM2;
      mem_write1  <= MemWriteM1;
      mem_write2  <= MemWriteM2;
      result_src1 <= ResultSrcM1;
      result_src2 <= ResultSrcM2;
      rd1         <= RD_M1;
      rd2         <= RD_M2;
      pc_plus4_1  <= PCPlus4M1;
      pc_plus4_2  <= PCPlus4M2;
      write_data1 <= WriteDataM1;
      write_data2 <= WriteDataM2;
      alu_result1 <= ALU_ResultM1;
      alu_result2 <= ALU_ResultM2;
    end
  end

  assign need1    = mem_write1 | result_src1;
  assign need2    = mem_write2 | result_src2;
  assign conflict = need1 & need2;

  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    sel2       = 1'b0;
    case (state)
      IDLE: begin
        if (conflict) begin
          StallM     = ~rst;
          state_next = SERVE2;
        end else begin
          sel2 = ~need1;
        end
      end
      SERVE2: begin
        sel2       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Single shared port: lane 2 only when it is alone or in the second conflict cycle
  assign mem_idx   = sel2 ? alu_result2[IDX_W+1:2] : alu_result1[IDX_W+1:2];
  assign mem_we    = sel2 ? mem_write2 : mem_write1;
  assign mem_wdata = sel2 ? write_data2 : write_data1;
  assign mem_rdata = mem[mem_idx];

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_idx] <= mem_wdata;
  end

  assign lane1_rdata = (state == SERVE2) ? hold1 : mem_rdata;

  // MEM/WB registers; the first conflict cycle retires a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      hold1        <= '0;
      RegWriteW1   <= 1'b0;
      RegWriteW2   <= 1'b0;
      ResultSrcW1  <= 1'b0;
      ResultSrcW2  <= 1'b0;
      RD_W1        <= '0;
      RD_W2        <= '0;
      PCPlus4W1    <= '0;
      PCPlus4W2    <= '0;
      ALU_ResultW1 <= '0;
      ALU_ResultW2 <= '0;
      ReadDataW1   <= '0;
      ReadDataW2   <= '0;
    end else if (state == IDLE && conflict) begin
      hold1      <= mem_rdata;
      RegWriteW1 <= 1'b0;
      RegWriteW2 <= 1'b0;
    end else begin
      RegWriteW1   <= reg_write1;
      RegWriteW2   <= reg_write2;
      ResultSrcW1  <= result_src1;
      ResultSrcW2  <= result_src2;
      RD_W1        <= rd1;
      RD_W2        <= rd2;
      PCPlus4W1    <= pc_plus4_1;
      PCPlus4W2    <= pc_plus4_2;
      ALU_ResultW1 <= alu_result1;
      ALU_ResultW2 <= alu_result2;
      ReadDataW1   <= result_src1 ? lane1_rdata : '0;
      ReadDataW2   <= result_src2 ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_memory_cycle_dual_pe.sv
// Self-checking bench for memory_cycle_dual_pe: directed scenarios plus randomized
// bundles checked against a transaction-level model with a flat memory array.
module tb_memory_cycle_dual_pe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteM1, RegWriteM2, MemWriteM1, MemWriteM2, ResultSrcM1, ResultSrcM2;
  logic [4:0]  RD_M1, RD_M2;
  logic [31:0] PCPlus4M1, PCPlus4M2, WriteDataM1, WriteDataM2, ALU_ResultM1, ALU_ResultM2;
  logic        StallM, RegWriteW1, RegWriteW2, ResultSrcW1, ResultSrcW2;
  logic [4:0]  RD_W1, RD_W2;
  logic [31:0] PCPlus4W1, PCPlus4W2, ALU_ResultW1, ALU_ResultW2, ReadDataW1, ReadDataW2;

  always #5 clk = ~clk;

  memory_cycle_dual_pe #(.DMEM_WORDS(1024), .IDX_W(10)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM1(RegWriteM1), .RegWriteM2(RegWriteM2),
    .MemWriteM1(MemWriteM1), .MemWriteM2(MemWriteM2),
    .ResultSrcM1(ResultSrcM1), .ResultSrcM2(ResultSrcM2),
    .RD_M1(RD_M1), .RD_M2(RD_M2),
    .PCPlus4M1(PCPlus4M1), .PCPlus4M2(PCPlus4M2),
    .WriteDataM1(WriteDataM1), .WriteDataM2(WriteDataM2),
    .ALU_ResultM1(ALU_ResultM1), .ALU_ResultM2(ALU_ResultM2),
    .StallM(StallM),
    .RegWriteW1(RegWriteW1), .RegWriteW2(RegWriteW2),
    .ResultSrcW1(ResultSrcW1), .ResultSrcW2(ResultSrcW2),
    .RD_W1(RD_W1), .RD_W2(RD_W2),
    .PCPlus4W1(PCPlus4W1), .PCPlus4W2(PCPlus4W2),
    .ALU_ResultW1(ALU_ResultW1), .ALU_ResultW2(ALU_ResultW2),
    .ReadDataW1(ReadDataW1), .ReadDataW2(ReadDataW2)
  );

  typedef struct packed {
    logic rw, mw, rs;
    logic [4:0] rd;
    logic [31:0] pc, wd, addr;
  } lane_t;
  typedef struct packed { lane_t l1, l2; } bundle_t;
  typedef struct packed {
    logic rw1, rs1; logic [4:0] rd1; logic [31:0] pc1, alu1, rdd1;
    logic rw2, rs2; logic [4:0] rd2; logic [31:0] pc2, alu2, rdd2;
  } ret_t;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] mdl [int];
  int pool [8] = '{0, 4, 8, 16, 32, 100, 512, 1023};
  localparam bundle_t NOP = '0;

  function automatic lane_t mk(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                               input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] addr);
    lane_t l;
    l.rw = rw; l.mw = mw; l.rs = rs; l.rd = rd; l.pc = pc; l.wd = wd; l.addr = addr;
    return l;
  endfunction

  function automatic bundle_t bnd(input lane_t a, input lane_t b);
    bundle_t x;
    x.l1 = a; x.l2 = b;
    return x;
  endfunction

  function automatic ret_t observe();
    ret_t r;
    r.rw1 = RegWriteW1; r.rs1 = ResultSrcW1; r.rd1 = RD_W1; r.pc1 = PCPlus4W1;
    r.alu1 = ALU_ResultW1; r.rdd1 = ReadDataW1;
    r.rw2 = RegWriteW2; r.rs2 = ResultSrcW2; r.rd2 = RD_W2; r.pc2 = PCPlus4W2;
    r.alu2 = ALU_ResultW2; r.rdd2 = ReadDataW2;
    return r;
  endfunction

  // Sequential semantics: lane 1 then lane 2, against a flat word array
  function automatic ret_t model(input bundle_t b);
    ret_t r;
    int i1, i2;
    i1 = int'(b.l1.addr[11:2]);
    i2 = int'(b.l2.addr[11:2]);
    if (b.l1.mw) mdl[i1] = b.l1.wd;
    r.rdd1 = b.l1.rs ? mdl[i1] : 32'h0;
    if (b.l2.mw) mdl[i2] = b.l2.wd;
    r.rdd2 = b.l2.rs ? mdl[i2] : 32'h0;
    r.rw1 = b.l1.rw; r.rs1 = b.l1.rs; r.rd1 = b.l1.rd; r.pc1 = b.l1.pc; r.alu1 = b.l1.addr;
    r.rw2 = b.l2.rw; r.rs2 = b.l2.rs; r.rd2 = b.l2.rd; r.pc2 = b.l2.pc; r.alu2 = b.l2.addr;
    return r;
  endfunction

  function automatic lane_t rand_lane(input int op, input int idx);
    lane_t l;
    logic [31:0] a;
    a = $urandom;
    a[11:2] = idx[9:0];
    l.rw = 1'($urandom); l.rd = 5'($urandom); l.pc = $urandom; l.wd = $urandom;
    l.mw = (op == 1); l.rs = (op == 2);
    l.addr = (op != 0) ? a : $urandom;
    return l;
  endfunction

  function automatic bundle_t gen(input int k);
    bundle_t b;
    if (k < 4) begin
      b.l1 = rand_lane(1, pool[2*k]);
      b.l2 = rand_lane(1, pool[2*k+1]);
    end else begin
      b.l1 = rand_lane($urandom_range(0, 2), pool[$urandom_range(0, 7)]);
      b.l2 = rand_lane($urandom_range(0, 2), pool[$urandom_range(0, 7)]);
    end
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    RegWriteM1 = b.l1.rw; MemWriteM1 = b.l1.mw; ResultSrcM1 = b.l1.rs; RD_M1 = b.l1.rd;
    PCPlus4M1 = b.l1.pc; WriteDataM1 = b.l1.wd; ALU_ResultM1 = b.l1.addr;
    RegWriteM2 = b.l2.rw; MemWriteM2 = b.l2.mw; ResultSrcM2 = b.l2.rs; RD_M2 = b.l2.rd;
    PCPlus4M2 = b.l2.pc; WriteDataM2 = b.l2.wd; ALU_ResultM2 = b.l2.addr;
  endtask

  // One clock: present inputs, note StallM before the edge, sample 1 time unit after
  task automatic tick(input bundle_t b, output logic stall);
    drive(b);
    #1;
    stall = StallM;
    @(posedge clk);
    #1;
  endtask

  // Repeat the bundle until the stage accepts it; reports how many cycles it was held
  task automatic issue(input bundle_t b, output int stalls);
    logic s;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      tick(b, s);
      if (!s) break;
      stalls++;
    end
  endtask

  task automatic test_reset();
    logic s;
    int st;
    bundle_t b;
    issue(bnd(mk(0, 1, 0, 0, 0, 32'h12345678, 32'h10), '0), st);
    issue(NOP, st);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b = gen(10);
      b.l1.mw = 1'b1; b.l1.rs = 1'b0; b.l1.addr = 32'h10;
      b.l2.mw = 1'b1; b.l2.rs = 1'b0; b.l2.addr = 32'h10;
      tick(b, s);
      vectors++;
      if (s !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", s); end
      vectors++;
      if (observe() !== ret_t'(0)) begin errors++; $display("FAIL reset_w got=%h exp=0", observe()); end
    end
    rst = 1'b0;
    issue(bnd(mk(1, 0, 1, 1, 0, 0, 32'h10), '0), st);
    issue(NOP, st);
    vectors++;
    if (ReadDataW1 !== 32'h12345678) begin
      errors++; $display("FAIL reset_nowrite got=%h exp=12345678", ReadDataW1);
    end
  endtask

  task automatic test_store_load();
    int s0, s1, s2;
    issue(bnd(mk(0, 1, 0, 0, 32'h4, 32'hDEADBEEF, 32'h10), '0), s0);
    issue(bnd(mk(1, 0, 1, 5, 32'h8, 0, 32'h10), '0), s1);
    issue(NOP, s2);
    vectors++;
    if (s0 + s1 + s2 !== 0) begin errors++; $display("FAIL sl_stall got=%0d exp=0", s0 + s1 + s2); end
    vectors++;
    if (ReadDataW1 !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_data got=%h exp=deadbeef", ReadDataW1); end
    vectors++;
    if (RD_W1 !== 5'd5 || RegWriteW1 !== 1'b1) begin
      errors++; $display("FAIL sl_rd got=%0d/%b exp=5/1", RD_W1, RegWriteW1);
    end
  endtask

  task automatic test_conflict_load();
    logic s;
    bundle_t p, c;
    p = bnd(mk(1, 0, 0, 3, 32'h100, 0, 32'h44), mk(1, 0, 0, 4, 32'h104, 0, 32'h48));
    c = bnd(mk(1, 1, 0, 6, 32'h200, 32'h11111111, 32'h20), mk(1, 0, 1, 7, 32'h204, 0, 32'h20));
    tick(p, s);
    tick(c, s);
    vectors++;
    if (s !== 1'b0) begin errors++; $display("FAIL cf_pre_stall got=%b exp=0", s); end
    tick(NOP, s);
    vectors++;
    if (s !== 1'b1) begin errors++; $display("FAIL cf_stall got=%b exp=1", s); end
    vectors++;
    if (RegWriteW1 !== 1'b0 || RegWriteW2 !== 1'b0 || RD_W1 !== 5'd3 || PCPlus4W2 !== 32'h104 ||
        ALU_ResultW1 !== 32'h44) begin
      errors++;
      $display("FAIL cf_bubble got=%b%b rd1=%0d pc2=%h alu1=%h exp=00 rd1=3 pc2=104 alu1=44",
               RegWriteW1, RegWriteW2, RD_W1, PCPlus4W2, ALU_ResultW1);
    end
    tick(NOP, s);
    vectors++;
    if (s !== 1'b0) begin errors++; $display("FAIL cf_stall_once got=%b exp=0", s); end
    vectors++;
    if (ReadDataW2 !== 32'h11111111 || RD_W2 !== 5'd7 || RegWriteW2 !== 1'b1) begin
      errors++; $display("FAIL cf_lane2 got=%h/%0d/%b exp=11111111/7/1", ReadDataW2, RD_W2, RegWriteW2);
    end
    vectors++;
    if (RegWriteW1 !== 1'b1 || RD_W1 !== 5'd6 || ReadDataW1 !== 32'h0 || PCPlus4W1 !== 32'h200) begin
      errors++; $display("FAIL cf_lane1 got=%b/%0d/%h/%h exp=1/6/0/200", RegWriteW1, RD_W1, ReadDataW1, PCPlus4W1);
    end
  endtask

  task automatic test_double_store();
    int s0, s1, s2;
    issue(bnd(mk(0, 1, 0, 0, 0, 32'hA, 32'h40), mk(0, 1, 0, 0, 0, 32'hB, 32'h40)), s0);
    issue(bnd(mk(1, 0, 1, 9, 32'h300, 0, 32'h40), '0), s1);
    issue(NOP, s2);
    vectors++;
    if (s0 !== 0 || s1 !== 1 || s2 !== 0) begin
      errors++; $display("FAIL ds_stalls got=%0d%0d%0d exp=010", s0, s1, s2);
    end
    vectors++;
    if (ReadDataW1 !== 32'hB || RD_W1 !== 5'd9) begin
      errors++; $display("FAIL ds_data got=%h/%0d exp=0000000b/9", ReadDataW1, RD_W1);
    end
  endtask

  task automatic test_reset_serve2();
    logic s;
    int st;
    issue(bnd(mk(0, 1, 0, 0, 0, 32'h3, 32'h80), '0), st);
    tick(bnd(mk(1, 1, 0, 1, 0, 32'h77, 32'h84), mk(1, 1, 0, 2, 0, 32'h5, 32'h80)), s);
    tick(NOP, s);
    vectors++;
    if (s !== 1'b1) begin errors++; $display("FAIL rs_stall got=%b exp=1", s); end
    rst = 1'b1;
    tick(NOP, s);
    rst = 1'b0;
    #1;
    vectors++;
    if (StallM !== 1'b0 || observe() !== ret_t'(0)) begin
      errors++; $display("FAIL rs_after got=%b/%h exp=0/0", StallM, observe());
    end
    issue(bnd(mk(1, 0, 1, 2, 0, 0, 32'h80), mk(1, 0, 1, 3, 0, 0, 32'h84)), st);
    issue(NOP, st);
    vectors++;
    if (ReadDataW1 !== 32'h3 || ReadDataW2 !== 32'h77) begin
      errors++; $display("FAIL rs_mem got=%h/%h exp=00000003/00000077", ReadDataW1, ReadDataW2);
    end
  endtask

  task automatic test_wrap();
    int st;
    issue(bnd('0, mk(0, 1, 0, 0, 0, 32'hCAFE0001, 32'h1000)), st);
    issue(bnd(mk(1, 0, 1, 1, 0, 0, 32'h0), '0), st);
    issue(bnd('0, mk(1, 0, 1, 2, 0, 0, 32'h3)), st);
    vectors++;
    if (ReadDataW1 !== 32'hCAFE0001 || ReadDataW2 !== 32'h0) begin
      errors++; $display("FAIL wrap_ld0 got=%h/%h exp=cafe0001/0", ReadDataW1, ReadDataW2);
    end
    issue(NOP, st);
    vectors++;
    if (ReadDataW2 !== 32'hCAFE0001 || ReadDataW1 !== 32'h0 || RD_W2 !== 5'd2) begin
      errors++; $display("FAIL wrap_ld3 got=%h/%h/%0d exp=cafe0001/0/2", ReadDataW2, ReadDataW1, RD_W2);
    end
  endtask

  task automatic test_random(input int n);
    logic s, exp_stall, have;
    int applied, stall_left;
    bundle_t b;
    ret_t inflight, last_ret, exp_w;
    rst = 1'b1;
    tick(NOP, s);
    rst = 1'b0;
    inflight = '0; last_ret = '0; stall_left = 0; applied = 0; have = 1'b0;
    for (int cyc = 0; cyc < n * 3 && applied < n; cyc++) begin
      if (!have) begin b = gen(applied); have = 1'b1; end
      exp_stall = (stall_left != 0);
      tick(b, s);
      vectors++;
      if (s !== exp_stall) begin errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, s, exp_stall); end
      if (exp_stall) begin
        exp_w = last_ret; exp_w.rw1 = 1'b0; exp_w.rw2 = 1'b0;
        stall_left = 0;
      end else begin
        exp_w = inflight; last_ret = inflight;
        inflight = model(b);
        stall_left = ((b.l1.mw | b.l1.rs) & (b.l2.mw | b.l2.rs)) ? 1 : 0;
        applied++; have = 1'b0;
      end
      vectors++;
      if (observe() !== exp_w) begin errors++; $display("FAIL rand_w cyc=%0d got=%h exp=%h", cyc, observe(), exp_w); end
    end
    vectors++;
    if (applied != n) begin errors++; $display("FAIL rand_progress got=%0d exp=%0d", applied, n); end
  endtask

  initial begin
    drive(NOP);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_store_load();
    test_conflict_load();
    test_double_store();
    test_reset_serve2();
    test_wrap();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
